// File: rtl/ecall_responder_if.sv
// Request/response and console channels between the WB stage (master) and
// the ecall responder (slave); clk and reset stay outside the bundle.
interface ecall_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_num;
  logic [63:0] req_a0;
  logic [63:0] req_a1;
  logic [63:0] req_a2;
  logic        resp_valid;
  logic [63:0] resp_result;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        halted;
  logic [7:0]  exit_code;

  modport master (
    output req_valid, req_num, req_a0, req_a1, req_a2, con_ready,
    input  req_ready, resp_valid, resp_result, con_valid, con_data, halted, exit_code
  );

  modport slave (
    input  req_valid, req_num, req_a0, req_a1, req_a2, con_ready,
    output req_ready, resp_valid, resp_result, con_valid, con_data, halted, exit_code
  );
endinterface

// File: rtl/ecall_responder.sv
// Hardware ecall service (exit, brk, getpid, console putchar) with a console TX FIFO.
// Define ECALL_CYCLE_CNT_EN to add a free-running cycle counter served as syscall 113.
module ecall_responder #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [63:0] BRK_INIT    = 64'h0000_0000_0100_0000,
  parameter logic [63:0] BRK_LIMIT   = 64'h0000_0000_1000_0000,
  parameter logic [63:0] PID         = 64'd1,
  parameter logic [63:0] PUTCHAR_NUM = 64'd1024
) (
  input  logic               clk,
  input  logic               reset,
  ecall_responder_if.slave   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [63:0] NUM_EXIT       = 64'd93;
  localparam logic [63:0] NUM_EXIT_GROUP = 64'd94;
  localparam logic [63:0] NUM_BRK        = 64'd214;
  localparam logic [63:0] NUM_GETPID     = 64'd172;
  localparam logic [63:0] ENOSYS_RESULT  = 64'hFFFF_FFFF_FFFF_FFDA;

  typedef enum logic [2:0] {IDLE, EXEC, WAIT_FIFO, RESP, LOCK, HALTED} state_t;

  state_t      state;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_result;
  logic        halted;
  logic [7:0]  exit_code;
  logic [63:0] brk;
  logic [63:0] num_q;
  logic [63:0] a0_q;
  logic [7:0]  char_q;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0] count, count_next;
  logic             con_valid;
  logic [7:0]       con_data, head_next;
  logic             push, pop, full;

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_result = resp_result;
  assign bus.halted      = halted;
  assign bus.exit_code   = exit_code;
  assign bus.con_valid   = con_valid;
  assign bus.con_data    = con_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop  = con_valid && bus.con_ready;
    full = (count == CNT_W'(FIFO_DEPTH));
    push = 1'b0;
    if (state == EXEC)
      push = (num_q == PUTCHAR_NUM) && !full;
    else if (state == WAIT_FIFO)
      push = !full || pop;
    rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    // The byte being written becomes the head when it lands on the new read slot.
    if (count_next == '0)
      head_next = 8'h00;
    else if (push && (wr_ptr == rd_next))
      head_next = char_q;
    else
      head_next = mem[rd_next];
  end

  // NOTE: the storage array has no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= char_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      con_valid <= 1'b0;
      con_data  <= 8'h00;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr    <= rd_next;
      count     <= count_next;
      con_valid <= (count_next != '0);
      con_data  <= head_next;
    end
  end

`ifdef ECALL_CYCLE_CNT_EN
  logic [63:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cycle_cnt + 64'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_result <= '0;
      halted      <= 1'b0;
      exit_code   <= 8'h00;
      brk         <= BRK_INIT;
      num_q       <= '0;
      a0_q        <= '0;
      char_q      <= 8'h00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready) begin
            num_q     <= bus.req_num;
            a0_q      <= bus.req_a0;
            char_q    <= bus.req_a1[7:0];
            req_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          if (num_q == NUM_EXIT || num_q == NUM_EXIT_GROUP) begin
            halted     <= 1'b1;
            exit_code  <= a0_q[7:0];
            resp_valid <= 1'b0;
            state      <= HALTED;
          end else if (num_q == NUM_BRK) begin
            if (a0_q != '0 && a0_q >= BRK_INIT && a0_q < BRK_LIMIT) begin
              brk         <= a0_q;
              resp_result <= a0_q;
            end else begin
              resp_result <= brk;
            end
          end else if (num_q == NUM_GETPID) begin
            resp_result <= PID;
          end else if (num_q == PUTCHAR_NUM) begin
            if (full) begin
              resp_valid <= 1'b0;
              state      <= WAIT_FIFO;
            end else begin
              resp_result <= 64'd1;
            end
`ifdef ECALL_CYCLE_CNT_EN
          end else if (num_q == 64'd113) begin
            resp_result <= cycle_cnt;
`endif
          end else begin
            resp_result <= ENOSYS_RESULT;
          end
        end
        WAIT_FIFO: begin
          if (push) begin
            resp_result <= 64'd1;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP:    state <= LOCK;
        LOCK: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
